// File: rtl/msk_ctrl_pkg.sv
// Shared types for the masked round controller: FSM state encoding and counter width helper.
package msk_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  // Bits needed to hold 0..n, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/msk_ctrl_cnt.sv
// Modulo-MOD wrap counter: advances on en, clears on clr, wrap flags the terminal count.
module msk_ctrl_cnt
  import msk_ctrl_pkg::*;
#(
  parameter  int MOD = 2,
  localparam int W   = cnt_w(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    wrap  = (cnt_q == W'(MOD - 1));
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/msk_round_ctrl.sv
// Round sequencer for an enable-gated masked datapath; freezes every enable while randomness is missing.
// Defining MSK_ROUND_CTRL_FLUSH_EN adds a LAT-cycle FLUSH state after the result handshake.
module msk_round_ctrl
  import msk_ctrl_pkg::*;
#(
  parameter  int NROUNDS = 10,
  parameter  int LAT     = 2,
  localparam int RW      = cnt_w(NROUNDS),
  localparam int CW      = cnt_w(LAT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          rnd_valid,
  output logic          rnd_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sel_in,
  output logic          en_state,
  output logic          en_pipe,
  output logic [RW-1:0] round,
  output logic          last_round,
  output logic          flush
);

  state_e        state_q;
  state_e        state_d;
  logic          cyc_en;
  logic          cyc_wrap;
  logic [CW-1:0] cyc;
  logic          unused_cyc;
  logic          round_en;
  logic          round_wrap;
  logic [RW-1:0] round_cnt;

  msk_ctrl_cnt #(.MOD(LAT)) u_cyc_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (sel_in),
    .en   (cyc_en),
    .cnt  (cyc),
    .wrap (cyc_wrap)
  );

  msk_ctrl_cnt #(.MOD(NROUNDS)) u_round_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (sel_in),
    .en   (round_en),
    .cnt  (round_cnt),
    .wrap (round_wrap)
  );

  // Only the terminal flag of the cycle counter drives control.
  assign unused_cyc = ^cyc;

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    rnd_ready  = 1'b0;
    out_valid  = 1'b0;
    sel_in     = 1'b0;
    en_state   = 1'b0;
    en_pipe    = 1'b0;
    flush      = 1'b0;
    cyc_en     = 1'b0;
    round_en   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sel_in   = 1'b1;
          en_state = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        rnd_ready = 1'b1;
        // Without fresh randomness the whole datapath holds: no partial advance.
        if (rnd_valid) begin
          en_pipe = 1'b1;
          cyc_en  = 1'b1;
          if (cyc_wrap) begin
            en_state = 1'b1;
            round_en = 1'b1;
            if (round_wrap) begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
`ifdef MSK_ROUND_CTRL_FLUSH_EN
          state_d = FLUSH;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef MSK_ROUND_CTRL_FLUSH_EN
      FLUSH: begin
        flush   = 1'b1;
        en_pipe = 1'b1;
        cyc_en  = 1'b1;
        if (cyc_wrap) begin
          en_state = 1'b1;
          state_d  = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    round      = (state_q == RUN) ? round_cnt : '0;
    last_round = (state_q == RUN) && round_wrap;
    if (rst) begin
      in_ready   = 1'b0;
      rnd_ready  = 1'b0;
      out_valid  = 1'b0;
      sel_in     = 1'b0;
      en_state   = 1'b0;
      en_pipe    = 1'b0;
      flush      = 1'b0;
      cyc_en     = 1'b0;
      round_en   = 1'b0;
      round      = '0;
      last_round = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_msk_round_ctrl.sv
// Bench for msk_round_ctrl: instance a (4 rounds, latency 3) and instance b (1 round, latency 1).
module tb_msk_round_ctrl;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [2];
  logic in_valid [2];
  logic rnd_valid [2];
  logic out_ready [2];
  logic in_ready [2];
  logic rnd_ready [2];
  logic out_valid [2];
  logic sel_in [2];
  logic en_state [2];
  logic en_pipe [2];
  logic last_round [2];
  logic flush [2];
  logic [2:0] round_a;
  logic [0:0] round_b;
  logic [7:0] round_o [2];

  assign round_o[0] = {5'd0, round_a};
  assign round_o[1] = {7'd0, round_b};

  msk_round_ctrl #(.NROUNDS(4), .LAT(3)) u_a (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .rnd_valid(rnd_valid[0]), .rnd_ready(rnd_ready[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sel_in(sel_in[0]), .en_state(en_state[0]),
    .en_pipe(en_pipe[0]), .round(round_a), .last_round(last_round[0]), .flush(flush[0])
  );

  msk_round_ctrl #(.NROUNDS(1), .LAT(1)) u_b (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .rnd_valid(rnd_valid[1]), .rnd_ready(rnd_ready[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sel_in(sel_in[1]), .en_state(en_state[1]),
    .en_pipe(en_pipe[1]), .round(round_b), .last_round(last_round[1]), .flush(flush[1])
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic int nr_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int lt_of(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  // Model: busy from accept until result handshake, work = randomness-backed cycles completed,
  // fl = flush cycles still owed after the handshake.
  bit m_busy [2];
  int m_work [2];
  int m_fl   [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0;
      m_work[i] = 0;
      m_fl[i]   = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        bit idle_m, run_m, done_m;
        idle_m = !m_busy[i] && m_fl[i] == 0;
        run_m  = m_busy[i] && m_work[i] < nr_of(i) * lt_of(i);
        done_m = m_busy[i] && m_work[i] == nr_of(i) * lt_of(i);
        if (rst[i]) begin
          m_busy[i] = 1'b0; m_work[i] = 0; m_fl[i] = 0;
        end else if (idle_m && in_valid[i]) begin
          m_busy[i] = 1'b1; m_work[i] = 0;
        end else if (run_m && rnd_valid[i]) begin
          m_work[i]++;
        end else if (done_m && out_ready[i]) begin
          m_busy[i] = 1'b0; m_work[i] = 0;
`ifdef MSK_ROUND_CTRL_FLUSH_EN
          m_fl[i] = lt_of(i);
`endif
        end else if (m_fl[i] > 0) begin
          m_fl[i]--;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit idle, run, done, fa, r;
        int L, N;
        string p;
        p    = (i == 0) ? "a" : "b";
        L    = lt_of(i);
        N    = nr_of(i);
        r    = rst[i];
        idle = !m_busy[i] && m_fl[i] == 0;
        run  = m_busy[i] && m_work[i] < N * L;
        done = m_busy[i] && m_work[i] == N * L;
        fa   = m_fl[i] > 0;
        chk({p, ".in_ready"},  in_ready[i],  !r && idle);
        chk({p, ".rnd_ready"}, rnd_ready[i], !r && run);
        chk({p, ".out_valid"}, out_valid[i], !r && done);
        chk({p, ".sel_in"},    sel_in[i],    !r && idle && in_valid[i]);
        chk({p, ".en_pipe"},   en_pipe[i],   !r && ((run && rnd_valid[i]) || fa));
        chk({p, ".en_state"},  en_state[i],  !r && ((idle && in_valid[i]) ||
                                             (run && rnd_valid[i] && ((m_work[i] + 1) % L == 0)) ||
                                             (fa && m_fl[i] == 1)));
        chk({p, ".round"},     round_o[i],   (!r && run) ? m_work[i] / L : 0);
        chk({p, ".last_round"}, last_round[i], !r && run && (m_work[i] / L == N - 1));
        chk({p, ".flush"},     flush[i],     !r && fa);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs instance a from the first RUN cycle until out_valid; bit n of the masks is RUN cycle n.
  task automatic run_a(input logic [63:0] stall, output int cyc, output logic [63:0] es,
                       output logic [63:0] ep, output logic [127:0] rtr);
    cyc = 0; es = '0; ep = '0; rtr = '0;
    for (int n = 1; n <= 60; n++) begin
      rnd_valid[0] = !stall[n];
      #1;
      es[n] = en_state[0];
      ep[n] = en_pipe[0];
      rtr[2*n +: 2] = round_a[1:0];
      tick();
      if (out_valid[0]) begin
        cyc = n;
        break;
      end
    end
    rnd_valid[0] = 1'b1;
  endtask

  task automatic start_a();
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
  endtask

  task automatic finish_a();
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
`ifdef MSK_ROUND_CTRL_FLUSH_EN
    repeat (3) tick();
`endif
  endtask

  initial begin
    int cyc, acc, last;
    logic [63:0] es, ep;
    logic [127:0] rtr;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; in_valid[i] = 1'b0; rnd_valid[i] = 1'b0; out_ready[i] = 1'b0;
    end
    repeat (3) tick();
    chk("rst.in_ready", in_ready[0], 0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    chk("idle.in_ready", in_ready[0], 1);
    chk("idle.round", round_a, 0);

    // Plain run, randomness always present.
    rnd_valid[0] = 1'b1; in_valid[0] = 1'b1;
    #1;
    chk("t1.sel_in", sel_in[0], 1);
    chk("t1.en_state_accept", en_state[0], 1);
    tick();
    in_valid[0] = 1'b0;
    run_a(64'h0, cyc, es, ep, rtr);
    chk("t1.latency", cyc, 12);
    chk("t1.en_state_cycles", es[31:0], 32'h1248);
    chk("t1.en_pipe_cycles", ep[31:0], 32'h1FFE);
    chk("t1.round_c3", rtr[6 +: 2], 0);
    chk("t1.round_c4", rtr[8 +: 2], 1);
    chk("t1.round_c10", rtr[20 +: 2], 3);

    // Result held while the consumer stalls; start requests ignored.
    in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3.out_valid_hold", out_valid[0], 1);
      chk("t3.in_ready_busy", in_ready[0], 0);
      chk("t3.en_state_done", en_state[0], 0);
      chk("t3.flush_done", flush[0], 0);
      tick();
    end
    out_ready[0] = 1'b1;
    #1;
    chk("t3.out_valid_hs", out_valid[0], 1);
    tick();
    out_ready[0] = 1'b0;
`ifdef MSK_ROUND_CTRL_FLUSH_EN
    in_valid[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("t6.flush", flush[0], 1);
      chk("t6.in_ready", in_ready[0], 0);
      chk("t6.en_pipe", en_pipe[0], 1);
      chk("t6.en_state", en_state[0], k == 3);
      tick();
    end
`endif
    #1;
    chk("t3.idle_after_hs", in_ready[0], 1);
    chk("t3.not_started", rnd_ready[0], 0);
    in_valid[0] = 1'b0;
    tick();

    // Randomness withheld in RUN cycles 2 and 7.
    start_a();
    run_a(64'h84, cyc, es, ep, rtr);
    chk("t2.latency", cyc, 14);
    chk("t2.en_pipe_cycles", ep[31:0], 32'h7F7A);
    chk("t2.en_state_cycles", es[31:0], 32'h4910);
    chk("t2.round_c7_stall", rtr[14 +: 2], 1);
    chk("t2.round_c8", rtr[16 +: 2], 1);
    chk("t2.round_c13", rtr[26 +: 2], 3);
    finish_a();

    // Reset in the middle of round 2.
    start_a();
    repeat (7) tick();
    chk("t4.round_before_rst", round_a, 2);
    rst[0] = 1'b1;
    #1;
    chk("t4.in_ready_in_rst", in_ready[0], 0);
    chk("t4.en_pipe_in_rst", en_pipe[0], 0);
    tick();
    rst[0] = 1'b0;
    #1;
    chk("t4.idle_after_rst", in_ready[0], 1);
    chk("t4.round_after_rst", round_a, 0);
    chk("t4.no_out_valid", out_valid[0], 0);
    start_a();
    run_a(64'h0, cyc, es, ep, rtr);
    chk("t4.restart_latency", cyc, 12);
    finish_a();

    // Single round, single cycle latency, back-to-back starts.
    in_valid[1] = 1'b1; out_ready[1] = 1'b1; rnd_valid[1] = 1'b1;
    acc = 0; last = -1;
    for (int n = 0; n < 9; n++) begin
      #1;
      if (in_ready[1]) begin
        acc++;
`ifdef MSK_ROUND_CTRL_FLUSH_EN
        if (last >= 0) chk("t5.accept_gap", n - last, 4);
`else
        if (last >= 0) chk("t5.accept_gap", n - last, 3);
`endif
        last = n;
      end
      tick();
      if (n == 0) begin
        chk("t5.run_cycle", rnd_ready[1], 1);
        chk("t5.last_round", last_round[1], 1);
      end
      if (n == 1) chk("t5.out_valid_after_1", out_valid[1], 1);
    end
    chk("t5.accepts", acc, 3);
    in_valid[1] = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
